// File: rtl/password_pkg.sv
// rtl/password_pkg.sv - state/fail-code types and password sizes shared by programmer and validator
package password_pkg;

   localparam int PW_LEN    = 4;
   localparam int PW_ADDR_W = 2;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ENTER1 = 3'd1,
      ENTER2 = 3'd2,
      WRITE  = 3'd3,
      VERIFY = 3'd4,
      DONE   = 3'd5,
      FAIL   = 3'd6
   } ProgState;

   typedef enum logic [1:0] {
      FC_NONE    = 2'd0,
      FC_INVALID = 2'd1,
      FC_CONFIRM = 2'd2,
      FC_VERIFY  = 2'd3
   } FailCode;

endpackage

// File: rtl/password_programmer_if.sv
// rtl/password_programmer_if.sv - keypad strobe and password-memory port of the programmer
interface password_programmer_if;
   import password_pkg::*;

   logic                 digit_valid;
   logic [3:0]           digit;
   logic [PW_ADDR_W-1:0] mem_addr;
   logic [3:0]           mem_wdata;
   logic                 mem_we;
   logic [3:0]           mem_rdata;

   modport master (
      input  digit_valid, digit, mem_rdata,
      output mem_addr, mem_wdata, mem_we
   );

   modport slave (
      output digit_valid, digit, mem_rdata,
      input  mem_addr, mem_wdata, mem_we
   );

endinterface

// File: rtl/password_programmer.sv
// rtl/password_programmer.sv - captures, confirms and burst-writes a new 4-digit password
// Optional read-back check of the written memory: define PW_PROG_VERIFY_EN.
module password_programmer
   import password_pkg::*;
#(
   parameter logic [3:0] DIGIT_MAX = 4'd9
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  lockDown,
   password_programmer_if.master bus,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [1:0]            fail_code
);

   ProgState             state, state_n;
   logic [PW_ADDR_W-1:0] cnt, cnt_n;
   logic [3:0]           pw_buf   [PW_LEN];
   logic [3:0]           pw_buf_n [PW_LEN];
   FailCode              code_n;
   logic                 we_n, done_n, fail_n;
   logic [PW_ADDR_W-1:0] addr_n;
   logic [3:0]           wdata_n;
   logic                 digit_ok, take_digit, cancel, last;

   assign digit_ok   = (bus.digit <= DIGIT_MAX);
   // a start in the same cycle as a keypress swallows the keypress
   assign take_digit = bus.digit_valid && !start;
   assign cancel     = abort || lockDown;
   assign last       = (cnt == PW_ADDR_W'(PW_LEN - 1));
   assign busy       = (state == ENTER1) || (state == ENTER2) ||
                       (state == WRITE)  || (state == VERIFY);

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state         <= IDLE;
         cnt           <= '0;
         pw_buf        <= '{default: '0};
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         done          <= 1'b0;
         fail          <= 1'b0;
         fail_code     <= FC_NONE;
      end else begin
         state         <= state_n;
         cnt           <= cnt_n;
         pw_buf        <= pw_buf_n;
         bus.mem_we    <= we_n;
         bus.mem_addr  <= addr_n;
         bus.mem_wdata <= wdata_n;
         done          <= done_n;
         fail          <= fail_n;
         fail_code     <= code_n;
      end
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      pw_buf_n = pw_buf;
      code_n   = FailCode'(fail_code);
      case (state)
         IDLE, DONE, FAIL: begin
            if (start && abort) begin
               state_n  = IDLE;
               cnt_n    = '0;
               pw_buf_n = '{default: '0};
               code_n   = FC_NONE;
            end else if (start && !lockDown) begin
               state_n = ENTER1;
               cnt_n   = '0;
               code_n  = FC_NONE;
            end
         end
         ENTER1: begin
            if (cancel) begin
               state_n  = IDLE;
               cnt_n    = '0;
               pw_buf_n = '{default: '0};
            end else if (take_digit) begin
               if (!digit_ok) begin
                  state_n = FAIL;
                  code_n  = FC_INVALID;
               end else begin
                  pw_buf_n[cnt] = bus.digit;
                  cnt_n         = cnt + 1'b1;
                  if (last) state_n = ENTER2;
               end
            end
         end
         ENTER2: begin
            if (cancel) begin
               state_n  = IDLE;
               cnt_n    = '0;
               pw_buf_n = '{default: '0};
            end else if (take_digit) begin
               if (!digit_ok) begin
                  state_n = FAIL;
                  code_n  = FC_INVALID;
               end else if (bus.digit != pw_buf[cnt]) begin
                  state_n = FAIL;
                  code_n  = FC_CONFIRM;
               end else begin
                  cnt_n = cnt + 1'b1;
                  if (last) state_n = WRITE;
               end
            end
         end
         WRITE: begin
            // the counter wraps back to zero as the burst ends
            cnt_n = cnt + 1'b1;
            if (last) begin
`ifdef PW_PROG_VERIFY_EN
               state_n = VERIFY;
`else
               state_n = DONE;
`endif
            end
         end
`ifdef PW_PROG_VERIFY_EN
         VERIFY: begin
            if (cancel) begin
               state_n  = IDLE;
               cnt_n    = '0;
               pw_buf_n = '{default: '0};
            end else if (bus.mem_rdata != pw_buf[cnt]) begin
               state_n = FAIL;
               code_n  = FC_VERIFY;
            end else begin
               cnt_n = cnt + 1'b1;
               if (last) state_n = DONE;
            end
         end
`endif
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
   end

   // outputs are registered from the next state so they line up with state/cnt
   always_comb begin
      we_n    = (state_n == WRITE);
      addr_n  = ((state_n == WRITE) || (state_n == VERIFY)) ? cnt_n : '0;
      wdata_n = we_n ? pw_buf_n[cnt_n] : 4'd0;
      done_n  = (state_n == DONE);
      fail_n  = (state_n == FAIL);
   end

endmodule
